// File: rtl/wavelet_sample_window_if.sv
// Sample-in / window-out bundle between a sample source and the wavelet window feeder.
// The master drives samples and flush; the slave (the window) drives the tap outputs.
interface wavelet_sample_window_if #(
  parameter int BITS_PER_ELEM = 8,
  parameter int NUM_ELEM      = 9,
  parameter int CNT_BITS      = 16
);
  logic                              i_sample_valid;
  logic [BITS_PER_ELEM-1:0]          i_sample;
  logic                              i_flush;
  logic [NUM_ELEM*BITS_PER_ELEM-1:0] o_taps;
  logic                              o_start_calc;
  logic                              o_window_full;
  logic [CNT_BITS-1:0]               o_calc_count;

  modport master (
    output i_sample_valid, i_sample, i_flush,
    input  o_taps, o_start_calc, o_window_full, o_calc_count
  );

  modport slave (
    input  i_sample_valid, i_sample, i_flush,
    output o_taps, o_start_calc, o_window_full, o_calc_count
  );
endinterface

// File: rtl/wavelet_sample_window.sv
// Sliding window of the last NUM_ELEM samples feeding the FIR wavelet stage,
// with a registered calc strobe issued once full and every DECIMATE accepts thereafter.
module wavelet_sample_window #(
  parameter int BITS_PER_ELEM = 8,
  parameter int NUM_ELEM      = 9,
  parameter int DECIMATE      = 1,
  parameter int CNT_BITS      = 16
) (
  input logic                     clk,
  input logic                     rst,
  wavelet_sample_window_if.slave  bus
);
  localparam int TW     = NUM_ELEM * BITS_PER_ELEM;
  localparam int FILL_W = $clog2(NUM_ELEM + 1);
  localparam int DEC_W  = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

  logic [TW-1:0]       taps_q, taps_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [DEC_W-1:0]    dec_q, dec_d;
  logic                start_q, start_d;
  logic                full_q, full_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                full_after;
  logic                strobe;

  always_comb begin
    taps_d     = taps_q;
    fill_d     = fill_q;
    dec_d      = dec_q;
    cnt_d      = cnt_q;
    start_d    = 1'b0;
    full_after = 1'b0;
    strobe     = 1'b0;
    if (bus.i_sample_valid) begin
      taps_d     = {taps_q[TW-BITS_PER_ELEM-1:0], bus.i_sample};
      fill_d     = (fill_q == FILL_W'(NUM_ELEM)) ? fill_q : fill_q + 1'b1;
      full_after = (fill_d == FILL_W'(NUM_ELEM));
      strobe     = full_after && (dec_q == '0);
      // Decimation phase only advances once the window is full, so the
      // filling accept always lands on phase 0 and strobes.
      if (!full_after)
        dec_d = '0;
      else
        dec_d = (dec_q == DEC_W'(DECIMATE - 1)) ? '0 : dec_q + 1'b1;
      start_d = strobe;
      if (strobe)
        cnt_d = cnt_q + 1'b1;
    end
    full_d = (fill_d == FILL_W'(NUM_ELEM));
  end

  // Flush clears exactly like reset; a sample arriving with flush is dropped.
  always_ff @(posedge clk) begin
    if (rst || bus.i_flush) begin
      taps_q  <= '0;
      fill_q  <= '0;
      dec_q   <= '0;
      start_q <= 1'b0;
      full_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      taps_q  <= taps_d;
      fill_q  <= fill_d;
      dec_q   <= dec_d;
      start_q <= start_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_taps        = taps_q;
  assign bus.o_start_calc  = start_q;
  assign bus.o_window_full = full_q;
  assign bus.o_calc_count  = cnt_q;
endmodule

// File: tb/tb_wavelet_sample_window.sv
// Randomized + directed bench: three window instances (plain, decimate-by-3, 4-bit counter)
// share one stimulus stream and are compared each cycle against a sample-history model.
module tb_wavelet_sample_window;
  localparam int BW = 8;
  localparam int NE = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wavelet_sample_window_if #(.BITS_PER_ELEM(BW), .NUM_ELEM(NE), .CNT_BITS(16)) ifa ();
  wavelet_sample_window_if #(.BITS_PER_ELEM(BW), .NUM_ELEM(NE), .CNT_BITS(16)) ifb ();
  wavelet_sample_window_if #(.BITS_PER_ELEM(BW), .NUM_ELEM(NE), .CNT_BITS(4))  ifc ();

  wavelet_sample_window #(.BITS_PER_ELEM(BW), .NUM_ELEM(NE), .DECIMATE(1), .CNT_BITS(16))
    u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  wavelet_sample_window #(.BITS_PER_ELEM(BW), .NUM_ELEM(NE), .DECIMATE(3), .CNT_BITS(16))
    u_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  wavelet_sample_window #(.BITS_PER_ELEM(BW), .NUM_ELEM(NE), .DECIMATE(1), .CNT_BITS(4))
    u_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: history of accepted samples since last clear; a strobe is due on
  // accept number n when n >= NE and (n - NE) is a multiple of the decimation.
  int         dec_of [3] = '{1, 3, 1};
  int         cbits  [3] = '{16, 16, 4};
  logic [7:0] hist   [3][$];
  int         acc    [3];
  int         strb   [3];
  bit         st     [3];
  int         prev_c;
  bit         wrap_seen;

  function automatic logic [127:0] exp_taps(input int c);
    logic [127:0] t = '0;
    int n = hist[c].size();
    for (int k = 0; k < NE; k++)
      if (k < n) t[k*BW +: BW] = hist[c][n-1-k];
    return t;
  endfunction

  task automatic model_edge(input bit r, input bit v, input logic [7:0] s, input bit f);
    for (int c = 0; c < 3; c++) begin
      if (r || f) begin
        hist[c].delete(); acc[c] = 0; strb[c] = 0; st[c] = 0;
      end else if (v) begin
        hist[c].push_back(s);
        if (hist[c].size() > NE) void'(hist[c].pop_front());
        acc[c]++;
        st[c] = (acc[c] >= NE) && ((acc[c] - NE) % dec_of[c] == 0);
        if (st[c]) strb[c]++;
      end else begin
        st[c] = 0;
      end
    end
  endtask

  task automatic check_one(input int c, input logic [127:0] taps, input logic s,
                           input logic full, input logic [15:0] cnt);
    chk($sformatf("taps%0d", c), taps, exp_taps(c));
    chk($sformatf("start%0d", c), 128'(s), 128'(st[c]));
    chk($sformatf("full%0d", c), 128'(full), 128'(acc[c] >= NE));
    chk($sformatf("count%0d", c), 128'(cnt), 128'(strb[c] % (1 << cbits[c])));
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] s, input bit f);
    rst = r;
    ifa.i_sample_valid = v; ifa.i_sample = s; ifa.i_flush = f;
    ifb.i_sample_valid = v; ifb.i_sample = s; ifb.i_flush = f;
    ifc.i_sample_valid = v; ifc.i_sample = s; ifc.i_flush = f;
    @(posedge clk);
    model_edge(r, v, s, f);
    #1;
    check_one(0, 128'(ifa.o_taps), ifa.o_start_calc, ifa.o_window_full, 16'(ifa.o_calc_count));
    check_one(1, 128'(ifb.o_taps), ifb.o_start_calc, ifb.o_window_full, 16'(ifb.o_calc_count));
    check_one(2, 128'(ifc.o_taps), ifc.o_start_calc, ifc.o_window_full, 16'(ifc.o_calc_count));
    if (prev_c == 15 && ifc.o_calc_count == 4'd0) wrap_seen = 1;
    prev_c = int'(ifc.o_calc_count);
  endtask

  task automatic accept(input logic [7:0] s);
    step(0, 1, s, 0);
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 0);
  endtask

  initial begin
    prev_c = 0; wrap_seen = 0;
    rst = 1;
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    chk("rst_taps", 128'(ifa.o_taps), 128'd0);
    chk("rst_count", 128'(ifa.o_calc_count), 128'd0);

    // Basic fill and sliding
    for (int i = 1; i <= 9; i++) accept(8'(i));
    chk("fill_taps", 128'(ifa.o_taps), 128'h010203040506070809);
    chk("fill_full", 128'(ifa.o_window_full), 128'd1);
    chk("fill_start", 128'(ifa.o_start_calc), 128'd1);
    chk("fill_count", 128'(ifa.o_calc_count), 128'd1);
    accept(8'h0A);
    chk("slide1_taps", 128'(ifa.o_taps), 128'h02030405060708090A);
    chk("slide1_start", 128'(ifa.o_start_calc), 128'd1);
    accept(8'hFF);
    chk("slide2_taps", 128'(ifa.o_taps), 128'h030405060708090AFF);
    chk("slide2_start", 128'(ifa.o_start_calc), 128'd1);
    chk("slide2_count", 128'(ifa.o_calc_count), 128'd3);

    // Decimation with random gaps
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 15; i++) begin
      int gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) idle();
      accept(8'($urandom));
    end
    chk("dec_count", 128'(ifb.o_calc_count), 128'd3);
    chk("dec_full", 128'(ifb.o_window_full), 128'd1);

    // Flush with a sample on the same edge
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) accept(8'(8'h30 + i));
    step(0, 1, 8'h55, 1);
    chk("flush_taps", 128'(ifa.o_taps), 128'd0);
    chk("flush_full", 128'(ifa.o_window_full), 128'd0);
    for (int i = 0; i < 9; i++) accept(8'(8'h60 + i));
    chk("flush_taps9", 128'(ifa.o_taps), 128'h606162636465666768);
    chk("flush_count", 128'(ifa.o_calc_count), 128'd1);

    // Reset mid-operation with decimation phase 1
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 9; i++) accept(8'($urandom));
    step(1, 0, 8'h00, 0);
    chk("mrst_taps", 128'(ifb.o_taps), 128'd0);
    chk("mrst_full", 128'(ifb.o_window_full), 128'd0);
    chk("mrst_start", 128'(ifb.o_start_calc), 128'd0);
    chk("mrst_count", 128'(ifb.o_calc_count), 128'd0);
    for (int i = 0; i < 8; i++) accept(8'($urandom));
    chk("mrst_nostrobe8", 128'(ifb.o_start_calc), 128'd0);
    accept(8'($urandom));
    chk("mrst_strobe9", 128'(ifb.o_start_calc), 128'd1);

    // Counter wrap on the 4-bit instance
    step(0, 0, 8'h00, 1);
    prev_c = 0; wrap_seen = 0;
    for (int i = 0; i < 25; i++) accept(8'($urandom));
    chk("wrap_count", 128'(ifc.o_calc_count), 128'd1);
    chk("wrap_seen", 128'(wrap_seen), 128'd1);

    // Random stress
    for (int i = 0; i < 600; i++) begin
      bit r = ($urandom_range(0, 99) == 0);
      bit f = ($urandom_range(0, 39) == 0);
      bit v = ($urandom_range(0, 2) != 0);
      step(r, v, 8'($urandom), f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wavelet_sample_window.md
Name: wavelet_sample_window

Overview:
Upstream feeder for the FIR wavelet stage. Accepts a stream of signed samples and keeps a sliding window of the last NUM_ELEM samples. Presents that window as a packed taps bus, and issues a one-cycle calculation strobe once the window is full, optionally decimated. Its o_taps and o_start_calc drive the FIR's taps and i_start_calc inputs directly.

Parameters:
BITS_PER_ELEM, 8, width of one sample / tap element
NUM_ELEM, 9, window length (taps); must be >= 2
DECIMATE, 1, one strobe per DECIMATE accepted samples once full; must be >= 1
CNT_BITS, 16, width of o_calc_count

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
i_sample_valid  in  1  i_sample is accepted on this rising edge (no backpressure, always ready)
i_sample  in  BITS_PER_ELEM  signed input sample
i_flush  in  1  synchronous window clear
o_taps  out  NUM_ELEM*BITS_PER_ELEM  packed window; element k at bits [k*BITS_PER_ELEM +: BITS_PER_ELEM]
o_start_calc  out  1  one-cycle strobe: o_taps holds a new full window to process
o_window_full  out  1  high when NUM_ELEM samples have been accepted since reset/flush
o_calc_count  out  CNT_BITS  number of strobes issued since reset/flush, wraps

Behaviour:
- Reset: already decided — reset rst, synchronous, active-high; clock clk.
  - On rst, all of the following clear to 0: o_taps, o_start_calc, o_window_full, o_calc_count, internal fill counter, internal decimation counter.
  - rst has priority over everything.
- Window ordering:
  - Element 0 is the newest sample; element NUM_ELEM-1 is the oldest.
  - On accept: o_taps <= {o_taps[(NUM_ELEM-1)*BITS_PER_ELEM-1:0], i_sample}. The oldest element is discarded.
- Fill counter:
  - Range 0..NUM_ELEM. Increments per accept and saturates at NUM_ELEM.
  - o_window_full is registered: fill == NUM_ELEM, visible the cycle after the NUM_ELEM-th accept.
- Decimation counter:
  - Range 0..DECIMATE-1. Held at 0 while the window is not full (post-accept fill < NUM_ELEM).
  - Let an accept have post-accept fill == NUM_ELEM:
    - if dec_cnt == 0, a strobe is issued;
    - dec_cnt <= (dec_cnt == DECIMATE-1) ? 0 : dec_cnt+1.
  - So the first strobe always comes on the accept that fills the window.
- o_start_calc:
  - Registered. High for exactly the one cycle after a strobe-issuing accept edge; low otherwise.
  - The o_taps update and the strobe land on the same edge, so the strobe cycle always shows the new window.
  - A new accept during the strobe cycle is legal. The consumer samples o_taps at that edge, i.e. pre-shift values.
  - Back-to-back accepts with DECIMATE=1 give a continuously high strobe: one calculation per cycle.
- o_calc_count increments by 1 on each strobe-issuing edge, modulo 2^CNT_BITS.
- Cycles with i_sample_valid=0: all state holds; o_start_calc drops to 0.
- i_flush:
  - Same effect as rst on every register listed above.
  - A sample presented together with i_flush is dropped.
  - A strobe pending for that edge is suppressed.
- Arithmetic: no arithmetic on sample data; samples are stored bit-exact. Counters are unsigned.
- No combinational path from any input to any output.

Test Plan:
- Basic fill, NUM_ELEM=9, DECIMATE=1:
  - stimulus: rst 2 cycles, then accept 0x01..0x09 on consecutive cycles;
  - required: after the 9th edge o_taps=0x010203040506070809, o_window_full=1, o_start_calc=1 for that cycle, o_calc_count=1; no strobe during the first 8 accepts.
- Sliding:
  - stimulus: continue with 0x0A, 0xFF;
  - required: o_taps=0x0203040506070809_0A, then 0x030405060708090AFF; strobe high both cycles; o_calc_count=3.
- Decimation, DECIMATE=3:
  - stimulus: accept 15 samples with valid gaps of 0–2 cycles;
  - required: strobes only after accepts 9, 12 and 15; each strobe 1 cycle wide; o_calc_count=3; all outputs hold across gaps.
- Flush:
  - stimulus: 5 accepts, then i_flush together with valid (sample 0x55), then 9 accepts;
  - required: 0x55 is absent; o_taps=0 and o_window_full=0 right after the flush; the first strobe comes only after the 9th post-flush accept; o_calc_count restarts at 1.
- Reset mid-operation:
  - stimulus: full window with DECIMATE=3 and dec_cnt=1, then rst for 1 cycle;
  - required: all outputs 0; re-fill needs 9 new samples; first strobe on the 9th.
- Counter wrap:
  - stimulus: CNT_BITS=4, DECIMATE=1, 25 consecutive accepts;
  - required: 17 strobes; o_calc_count sequence reaches 15 then 0, ending at 1.
